// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// FifoSyncParam (module fifo_sync_param)
//
// Purpose:
//    Parametrised single-clock FIFO placed between a producer and a consumer
//    in the same clock domain. Configurable word width and power-of-two depth,
//    a registered occupancy count, programmable almost-full / almost-empty
//    thresholds and sticky overflow / underflow error flags.
//
// Build option:
//    FIFO_FWFT_EN  - when defined, the read port works in first-word
//                    fall-through mode: rd_data always shows the head entry,
//                    rd_valid = !empty, and rd_en pops the head.
//                    When undefined, a read accepted at an edge loads rd_data
//                    at that edge and rd_valid is high for the following cycle.
//
// Parameters:
//    WIDTH     data word width in bits (>= 1)
//    DEPTH     number of entries, power of two, >= 2
//    AF_LEVEL  almost_full  asserts when count >= AF_LEVEL (1..DEPTH)
//    AE_LEVEL  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//    clk           in   rising-edge clock
//    reset         in   synchronous active-high reset
//    wr_en         in   write request
//    wr_data       in   write data (WIDTH)
//    rd_en         in   read request / pop
//    rd_data       out  read data (WIDTH)
//    rd_valid      out  rd_data is valid
//    full          out  count == DEPTH
//    empty         out  count == 0
//    almost_full   out  count >= AF_LEVEL
//    almost_empty  out  count <= AE_LEVEL
//    count         out  occupancy 0..DEPTH (AW+1 bits)
//    overflow      out  sticky: a write was rejected
//    underflow     out  sticky: a read was rejected
//    clr_err       in   clears overflow and underflow
// ---------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds and constants sized to the count/pointer width so every
    // comparison below is between equal-width operands.
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL_C = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL_C = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_C    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_C   = '0;

    // Storage array; intentionally not reset.
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit above the storage index.
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;

    // Occupancy and every status flag are registered and all derived from
    // the same next-count value, so they can never disagree with each other.
    logic [AW:0] count_q, count_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        almostFull_q, almostFull_d;
    logic        almostEmpty_q, almostEmpty_d;

    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        wrAccept;
    logic        rdAccept;
    logic        wrReject;
    logic        rdReject;

    logic [AW-1:0] wrIdx;
    logic [AW-1:0] rdIdx;

    assign wrIdx = wrPtr_q[AW-1:0];
    assign rdIdx = rdPtr_q[AW-1:0];

    // ------------------------------------------------------------------
    // Request qualification. Acceptance uses the registered full/empty
    // state from before the edge, so a write into a full FIFO is dropped
    // even if a read frees a slot in the same cycle, and a read from an
    // empty FIFO is dropped even if a write arrives in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        wrAccept = wr_en && !full_q;
        rdAccept = rd_en && !empty_q;
        wrReject = wr_en && full_q;
        rdReject = rd_en && empty_q;
    end

    // ------------------------------------------------------------------
    // Next-state for pointers, count, flags and sticky errors.
    // ------------------------------------------------------------------
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + ONE_C;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + ONE_C;
        end

        // Simultaneous accepted read and write leave the count unchanged.
        if (wrAccept && !rdAccept) begin
            count_d = count_q + ONE_C;
        end else if (rdAccept && !wrAccept) begin
            count_d = count_q - ONE_C;
        end

        full_d        = (count_d == DEPTH_C);
        empty_d       = (count_d == ZERO_C);
        almostFull_d  = (count_d >= AF_LVL_C);
        almostEmpty_d = (count_d <= AE_LVL_C);

        // A fresh error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (overflow_q  && !clr_err) || wrReject;
        underflow_d = (underflow_q && !clr_err) || rdReject;
    end

    // ------------------------------------------------------------------
    // Control and status registers. Reset discards all stored entries by
    // rewinding the pointers; requests during reset are ignored and raise
    // no errors.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= (DEPTH_C == ZERO_C);
            empty_q       <= 1'b1;
            almostFull_q  <= (AF_LVL_C == ZERO_C);
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almostFull_q  <= almostFull_d;
            almostEmpty_q <= almostEmpty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage write port. No reset so it maps onto plain flops or a
    // register file.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && wrAccept) begin
            mem[wrIdx] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // ------------------------------------------------------------------
    // First-word fall-through read port. The head entry is shown directly
    // from storage; while empty the output is forced to zero so stale
    // (possibly never-written) storage never leaks onto rd_data.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] headData;

    always_comb begin
        headData = mem[rdIdx];
        if (empty_q) begin
            rd_data = '0;
        end else begin
            rd_data = headData;
        end
        rd_valid = !empty_q;
    end
`else
    // ------------------------------------------------------------------
    // Registered read port. An accepted read captures the head at the
    // edge; rd_valid flags the single following cycle, otherwise rd_data
    // keeps its last value.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rdData_q, rdData_d;
    logic             rdValid_q, rdValid_d;

    always_comb begin
        rdData_d  = rdData_q;
        rdValid_d = rdAccept;
        if (rdAccept) begin
            rdData_d = mem[rdIdx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
        end
    end

    assign rd_data  = rdData_q;
    assign rd_valid = rdValid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almostFull_q;
    assign almost_empty = almostEmpty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, the next generation of the team's single-bit FIFO: configurable data width and power-of-two depth, registered occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain in the Tiny Tapeout user design. An optional first-word-fall-through read mode is available.

## Interface
- `WIDTH`, 8: data word width in bits (≥1).
- `DEPTH`, 16: number of entries. Must be a power of two, ≥2. `AW = log2(DEPTH)`.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL (1..DEPTH).
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL (0..DEPTH-1).

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  WIDTH  write data.
- `rd_en`  in  1  read request (pop).
- `rd_data`  out  WIDTH  read data.
- `rd_valid`  out  1  `rd_data` is valid (meaning depends on mode).
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was rejected.
- `underflow`  out  1  sticky: a read was rejected.
- `clr_err`  in  1  clears `overflow` and `underflow`.

## Operation
- Pointers are AW+1 bits wide. The low AW bits index storage and the MSB is the wrap bit. Pointers wrap naturally modulo 2·DEPTH.
- All flags and `count` are registered and come from one `count` register, so they always agree.
- Write accept: `wr_en && !full`, with `full` sampled before the edge. A write to a full FIFO is dropped, even when a read is accepted in the same cycle, and sets `overflow`.
- Read accept: `rd_en && !empty`. A read of an empty FIFO is dropped, even when a write is accepted in the same cycle, and sets `underflow`.
- Accepted write and accepted read in the same cycle: `count` is unchanged and both pointers advance.
- Next `count` = `count` + (write accepted) − (read accepted).
- `clr_err`: `overflow` and `underflow` go to 0 on the next edge. If a new error occurs in the same cycle as `clr_err`, the error wins and the flag stays 1.
- Reset: pointers 0, `count` 0, `empty` 1, `almost_empty` 1, `full` 0, `almost_full` 0 (1 if AF_LEVEL==0, illegal), `overflow` 0, `underflow` 0, `rd_data` 0, `rd_valid` 0. Storage contents are not reset.
- Reset asserted mid-operation discards all stored data. Any request in that cycle is ignored and no error flag is set.

## Timing
- A write accepted at edge N updates `count`, `empty` and `almost_*` after edge N. The word can be read at edge N+1.
- Standard mode: a read accepted at edge N loads `rd_data` at edge N, and `rd_valid`=1 for exactly the cycle after N. Otherwise `rd_valid`=0 and `rd_data` holds its last value.
- `full` and `empty` never combinationally depend on `wr_en` or `rd_en`.
- Throughput is one write and one read per cycle.

## Configuration
- `FIFO_FWFT_EN` defined: first-word fall-through.
  - `rd_data` always presents the head entry and `rd_valid` = `!empty`.
  - `rd_en` acknowledges/pops the head. The next entry appears the cycle after the edge.
  - The first write into an empty FIFO at edge N gives `rd_valid`=1 after edge N.
  - Underflow rules are unchanged.
- `FIFO_FWFT_EN` undefined: the standard one-cycle registered read described above.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
- Reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> `count` 1,2,3,4; `almost_full` rises with count 3; `full`=1 after the 4th; `empty`=0 after the 1st.
- Full, then `wr_en` with 0x55 -> dropped, `overflow`=1, `count`=4. Then read 4 times -> `rd_data` 0x11, 0x22, 0x33, 0x44, each one cycle after its accept; `empty`=1 at the end.
- Empty, `rd_en` with `wr_en` (0xA5) in the same cycle -> write accepted, read rejected, `underflow`=1, `count`=1. `clr_err` pulse -> both flags 0.
- `count`=2, simultaneous read and write for 10 cycles with data 0..9 -> `count` stays 2; reads return the old 2 words, then 0..7 in order (covers pointer wrap).
- Full, simultaneous `rd_en` and `wr_en` -> read accepted, write dropped, `overflow`=1, `count`=3.
- `FIFO_FWFT_EN`: write 0x7E into empty -> next cycle `rd_valid`=1 and `rd_data`=0x7E with no `rd_en`. Pulse `rd_en` -> `rd_valid`=0. Apply reset with 3 entries stored -> `count`=0 and `empty`=1 after the edge.
